// File: rtl/pac_pkg.sv
// Shared types and constants for the Pac-Man sprite line fetcher.
package pac_pkg;

  localparam int SPR_SIZE = 16;
  localparam logic [3:0] TRANSPARENT = 4'h0;

  typedef enum logic [1:0] {
    DIR_R,
    DIR_L,
    DIR_U,
    DIR_D
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/spr_addr_map.sv
// Maps a sprite row/column and facing direction to a ROM address.
// Left mirrors horizontally; up and down transpose the source sprite.
module spr_addr_map
  import pac_pkg::*;
(
  input  logic [3:0] row,
  input  logic [3:0] col,
  input  dir_t       dir,
  output logic [7:0] addr
);

  always_comb begin
    addr = {row, col};
    unique case (dir)
      DIR_R: addr = {row, col};
      DIR_L: addr = {row, 4'd15 - col};
      DIR_U: addr = {col, row};
      DIR_D: addr = {4'd15 - col, row};
      default: addr = {row, col};
    endcase
  end

endmodule

// File: rtl/pacman_sprite_fetch.sv
// Fetches one oriented sprite row into a line buffer during h-blank, then
// serves registered palette indices for active video from that buffer.
module pacman_sprite_fetch
  import pac_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int IDX_W   = 4,
  parameter int ROM_LAT = 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               line_start,
  input  logic [COORD_W-1:0] next_y,
  input  logic [COORD_W-1:0] sprite_x,
  input  logic [COORD_W-1:0] sprite_y,
  input  logic [1:0]         dir,
  input  logic [COORD_W-1:0] DrawX,
  output logic [7:0]         rom_addr,
  input  logic [IDX_W-1:0]   rom_q,
  output logic [IDX_W-1:0]   pixel_idx,
  output logic               pixel_on,
  output logic               busy
);

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SPR_SIZE + ROM_LAT - 1);
  localparam logic [CNT_W-1:0] LAT_CNT  = CNT_W'(ROM_LAT);
  localparam logic [CNT_W-1:0] SPR_CNT  = CNT_W'(SPR_SIZE);

  fetch_state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cap_cnt;
  logic [COORD_W-1:0] sx_lat;
  logic [3:0]         row_lat;
  dir_t               dir_lat;
  logic               line_valid;
  logic [IDX_W-1:0]   line_buf [SPR_SIZE];

  logic [COORD_W-1:0] row_rel;
  logic               row_hit;
  logic [7:0]         map_addr;
  logic [COORD_W-1:0] dx;
  logic               hit;
  logic [IDX_W-1:0]   rd_idx;

  // Row offset wraps, so lines above the sprite look huge and are rejected.
  assign row_rel = next_y - sprite_y;
  assign row_hit = row_rel < COORD_W'(SPR_SIZE);

  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (line_start) begin
      state_nxt = row_hit ? FETCH : IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nxt = IDLE;
        FETCH:   if (cnt == LAST_CNT) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt        <= '0;
      sx_lat     <= '0;
      row_lat    <= '0;
      dir_lat    <= DIR_R;
      line_valid <= 1'b0;
    end else if (line_start) begin
      cnt        <= '0;
      sx_lat     <= sprite_x;
      row_lat    <= row_rel[3:0];
      dir_lat    <= dir_t'(dir);
      line_valid <= 1'b0;
    end else if (state == FETCH) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST_CNT) line_valid <= 1'b1;
    end
  end

  // ROM data trails its address by ROM_LAT cycles, so captures lag the column count.
  assign cap_cnt = cnt - LAT_CNT;

  always_ff @(posedge Clk) begin
    if (Reset_n && !line_start && state == FETCH && cnt >= LAT_CNT)
      line_buf[cap_cnt[3:0]] <= rom_q;
  end

  spr_addr_map u_addr_map (
    .row  (row_lat),
    .col  (cnt[3:0]),
    .dir  (dir_lat),
    .addr (map_addr)
  );

  assign rom_addr = (state == FETCH && cnt < SPR_CNT) ? map_addr : 8'd0;
  assign busy     = (state == FETCH);

  assign dx     = DrawX - sx_lat;
  assign hit    = line_valid && (dx < COORD_W'(SPR_SIZE));
  assign rd_idx = line_buf[dx[3:0]];

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pixel_idx <= '0;
      pixel_on  <= 1'b0;
    end else begin
      pixel_idx <= hit ? rd_idx : '0;
      pixel_on  <= hit && (rd_idx != IDX_W'(TRANSPARENT));
    end
  end

endmodule
